// File: rtl/input_debouncer.sv
// input_debouncer: synchronises a raw button/switch input, debounces it with a
// saturating stability counter and a 4-state FSM, and emits registered
// one-cycle rise/fall strobes alongside the clean level.
//
// Optional build macro: DEBOUNCE_COUNT_EN adds an 8-bit wrapping press counter
// (press_count) that advances on the edge after each rise_pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE_LOW  | level_out = 0, input agrees, counter held at 0
// WAIT_HIGH | level_out = 0, input seen high, counting stable samples
// IDLE_HIGH | level_out = 1, input agrees, counter held at 0
// WAIT_LOW  | level_out = 1, input seen low, counting stable samples
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       btn_in,
    output logic       level_out,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy
`ifdef DEBOUNCE_COUNT_EN
    ,
    output logic [7:0] press_count
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [1:0]             state_q;
    logic [1:0]             state_nxt;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;

    assign s = sync_q[SYNC_STAGES-1];

    // Metastability chain: btn_in enters at bit 0, s is the oldest stage.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    // Next state and counter; a change is accepted on the stable sample that
    // finds the counter already at its last value, so it never wraps.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                cnt_nxt = '0;
                if (s) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                cnt_nxt = '0;
                if (!s) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and all outputs registered together so level and strobes
    // change on the same edge as the state.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE_LOW;
            cnt_q      <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            level_out  <= (state_nxt == IDLE_HIGH) || (state_nxt == WAIT_LOW);
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            busy       <= (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
        end
    end

`ifdef DEBOUNCE_COUNT_EN
    // Press counter trails rise_pulse by one edge and wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            press_count <= 8'd0;
        end else if (rise_pulse) begin
            press_count <= press_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer: directed scenarios plus random input segments,
// checked cycle by cycle against a run-length reference model via a scoreboard.
module tb_input_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 16;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic       btn_in;
    logic       level_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       busy;
    logic [7:0] pc_act;

    int checks = 0;
    int errors = 0;

    input_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .btn_in     (btn_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
`ifdef DEBOUNCE_COUNT_EN
        ,
        .press_count(pc_act)
`endif
    );

`ifndef DEBOUNCE_COUNT_EN
    assign pc_act = 8'd0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic       level;
        logic       rise;
        logic       fall;
        logic       busy;
        logic [7:0] pc;
    } exp_t;

    exp_t q[$];

    // Reference model: the input seen by the debouncer lags btn_in by SYNC
    // edges; the level flips once DEB consecutive seen samples disagree with it.
    bit hist[$];
    bit m_level;
    bit m_run_val;
    int m_run_len;
    int m_presses;
    bit m_rise_prev;

    function automatic void model_reset();
        hist = {};
        for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
        m_level     = 1'b0;
        m_run_val   = 1'b0;
        m_run_len   = DEB;
        m_presses   = 0;
        m_rise_prev = 1'b0;
    endfunction

    function automatic exp_t model_edge(bit b);
        exp_t e;
        bit   seen;
        seen = hist.pop_front();
        hist.push_back(b);
        if (m_rise_prev) m_presses++;
        if (seen == m_run_val) begin
            if (m_run_len < DEB) m_run_len++;
        end else begin
            m_run_val = seen;
            m_run_len = 1;
        end
        e.rise = 1'b0;
        e.fall = 1'b0;
        if (m_run_len >= DEB && m_run_val != m_level) begin
            m_level = m_run_val;
            e.rise  = m_level;
            e.fall  = !m_level;
        end
        e.level     = m_level;
        e.busy      = (seen != m_level);
        e.pc        = 8'(m_presses);
        m_rise_prev = e.rise;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares the outputs produced by each clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("level", 32'(level_out), 32'(e.level));
                chk("rise", 32'(rise_pulse), 32'(e.rise));
                chk("fall", 32'(fall_pulse), 32'(e.fall));
                chk("busy", 32'(busy), 32'(e.busy));
`ifdef DEBOUNCE_COUNT_EN
                chk("press_count", 32'(pc_act), 32'(e.pc));
`endif
            end
        end
    end

    // Per-scenario event tracking.
    int edge_cnt, first_rise, first_fall, rise_cnt, fall_cnt, busy_first, busy_last;

    task automatic clear_track();
        edge_cnt   = 0;
        first_rise = -1;
        first_fall = -1;
        rise_cnt   = 0;
        fall_cnt   = 0;
        busy_first = -1;
        busy_last  = -1;
    endtask

    // Called just after a falling edge; drives one input value across one edge.
    task automatic tick(input bit b);
        btn_in = b;
        @(posedge clk);
        q.push_back(model_edge(b));
        @(negedge clk);
        #1;
        edge_cnt++;
        if (rise_pulse) begin
            rise_cnt++;
            if (first_rise < 0) first_rise = edge_cnt;
        end
        if (fall_pulse) begin
            fall_cnt++;
            if (first_fall < 0) first_fall = edge_cnt;
        end
        if (busy) begin
            if (busy_first < 0) busy_first = edge_cnt;
            busy_last = edge_cnt;
        end
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) tick(b);
    endtask

    task automatic do_reset(input int cycles, input bit b);
        exp_t z;
        z = '0;
        Reset_n = 1'b0;
        btn_in  = b;
        model_reset();
        #1;
        chk("rst_level", 32'(level_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pulses", 32'({rise_pulse, fall_pulse}), 0);
        chk("rst_count", 32'(pc_act), 0);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            q.push_back(z);
            @(negedge clk);
            #1;
        end
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n = 1'b0;
        btn_in  = 1'b1;
        model_reset();
        @(negedge clk);
        #1;

        // T1: reset held with input high, then a full-latency press after release.
        do_reset(4, 1'b1);
        clear_track();
        hold(1'b1, 25);
        chk("t1_rise_edge", 32'(first_rise), 18);
        chk("t1_level", 32'(level_out), 1);
        hold(1'b0, 25);

        // T2: clean press.
        clear_track();
        hold(1'b1, 25);
        chk("t2_rise_edge", 32'(first_rise), 18);
        chk("t2_rise_cnt", 32'(rise_cnt), 1);
        chk("t2_fall_cnt", 32'(fall_cnt), 0);
        chk("t2_busy_first", 32'(busy_first), 3);
        chk("t2_busy_last", 32'(busy_last), 17);
        clear_track();
        hold(1'b0, 25);
        chk("t2_fall_edge", 32'(first_fall), 18);

        // T3: bounce rejection.
        clear_track();
        for (int i = 0; i < 6; i++) begin
            hold(1'b1, 5);
            hold(1'b0, 5);
        end
        hold(1'b0, 20);
        chk("t3_rise_cnt", 32'(rise_cnt), 0);
        chk("t3_level", 32'(level_out), 0);

        // T4: bouncy press then clean release.
        clear_track();
        for (int i = 0; i < 3; i++) begin
            hold(1'b1, 3);
            hold(1'b0, 3);
        end
        hold(1'b1, 40);
        chk("t4_rise_cnt", 32'(rise_cnt), 1);
        clear_track();
        hold(1'b0, 30);
        chk("t4_fall_cnt", 32'(fall_cnt), 1);
        chk("t4_fall_edge", 32'(first_fall), 18);

        // T5: reset while counting towards a rise (counter = 10 after edge 12).
        clear_track();
        hold(1'b1, 12);
        chk("t5_busy_before", 32'(busy), 1);
        do_reset(2, 1'b1);
        clear_track();
        hold(1'b1, 25);
        chk("t5_rise_edge", 32'(first_rise), 18);
        hold(1'b0, 25);

        // Random segments with occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(0, 29) == 0) begin
                do_reset(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            end
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)));
        end
        hold(1'b0, 25);

`ifdef DEBOUNCE_COUNT_EN
        // T6: press counter wrap.
        do_reset(2, 1'b0);
        for (int p = 1; p <= 257; p++) begin
            hold(1'b1, 20);
            hold(1'b0, 20);
            if (p == 255) chk("t6_count_255", 32'(pc_act), 32'h0FF);
        end
        chk("t6_count_257", 32'(pc_act), 32'h001);
`endif

        hold(1'b0, 3);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
